// File: rtl/gpr_wr_arbiter_if.sv
// Writeback request bundle between the writeback sources and the GPR write port.
// The slave side is the arbiter; the master side is the collection of sources
// plus the GPR that consumes the registered write.
interface gpr_wr_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    logic                  hold;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*AW-1:0]   req_addr;
    logic [N_REQ*DW-1:0]   req_data;
    logic [N_REQ-1:0]      req_flag;
    logic [N_REQ*DW-1:0]   req_nflag;
    logic                  WE;
    logic [AW-1:0]         AWr;
    logic [DW-1:0]         Din;
    logic [1:0]            FlagOp;
    logic [DW-1:0]         NFlag;
    logic [1:0]            gnt_id;

    modport slave (
        input  hold, req_valid, req_addr, req_data, req_flag, req_nflag,
        output req_ready, WE, AWr, Din, FlagOp, NFlag, gnt_id
    );

    modport master (
        output hold, req_valid, req_addr, req_data, req_flag, req_nflag,
        input  req_ready, WE, AWr, Din, FlagOp, NFlag, gnt_id
    );
endinterface

// File: rtl/gpr_wr_arbiter.sv
// Round-robin arbiter sharing the GPR write port and flag-update port among
// N_REQ writeback sources (0=ALU, 1=load, 2=mul/div). One registered output
// stage drives the GPR directly; GPR commits on the edge after it loads.
module gpr_wr_arbiter #(
    parameter int N_REQ = 3,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              reset,
    gpr_wr_arbiter_if.slave   bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic       WR_EN              = 1'b1;
    localparam logic       WR_DIS             = 1'b0;
    localparam logic [1:0] FLAG_OP_DIS        = 2'd0;
    localparam logic [1:0] FLAG_OP_SET        = 2'd1;
    localparam logic [1:0] FLAG_OP_SET_AND_WR = 2'd2;

    logic [PW-1:0]    r_ptr;
    logic             r_we;
    logic [AW-1:0]    r_awr;
    logic [DW-1:0]    r_din;
    logic [1:0]       r_flag_op;
    logic [DW-1:0]    r_nflag;
    logic [1:0]       r_gnt_id;

    logic             w_gnt_vld;
    logic [PW-1:0]    w_gnt_idx;
    logic [N_REQ-1:0] w_ready;
    logic [PW-1:0]    w_ptr_nxt;
    logic [AW-1:0]    w_sel_addr;
    logic [DW-1:0]    w_sel_data;
    logic [DW-1:0]    w_sel_nflag;
    logic             w_sel_flag;
    logic             w_addr_nz;

    // Round-robin search starting at the pointer; ready is gated off during
    // reset and hold and never looks at the data fields.
    always_comb begin
        int v_idx;
        v_idx     = 0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        if (reset && !bus.hold) begin
            for (int k = 0; k < N_REQ; k++) begin
                v_idx = int'(r_ptr) + k;
                if (v_idx >= N_REQ) begin
                    v_idx = v_idx - N_REQ;
                end
                if (!w_gnt_vld && bus.req_valid[PW'(v_idx)]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = PW'(v_idx);
                end
            end
        end
    end

    // One-hot ready plus the payload mux for the granted source.
    always_comb begin
        w_ready     = '0;
        w_sel_addr  = '0;
        w_sel_data  = '0;
        w_sel_nflag = '0;
        w_sel_flag  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_idx == PW'(i)) begin
                w_ready[i]  = w_gnt_vld;
                w_sel_addr  = bus.req_addr[i*AW +: AW];
                w_sel_data  = bus.req_data[i*DW +: DW];
                w_sel_nflag = bus.req_nflag[i*DW +: DW];
                w_sel_flag  = bus.req_flag[i];
            end
        end
    end

    // Explicit wrap so non-power-of-two source counts rotate correctly.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_gnt_vld) begin
            if (w_gnt_idx == PW'(N_REQ - 1)) begin
                w_ptr_nxt = '0;
            end else begin
                w_ptr_nxt = PW'(w_gnt_idx + PW'(1));
            end
        end
    end

    assign w_addr_nz = (w_sel_addr != '0);

    // Pointer register; only a completed transfer moves it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Output stage: reloads on every transfer, otherwise write/flag strobes
    // drop while address/data/id hold their last value. Writes to $0 are
    // consumed but never strobe WE; the flag part still goes through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we      <= WR_DIS;
            r_flag_op <= FLAG_OP_DIS;
            r_awr     <= '0;
            r_din     <= '0;
            r_nflag   <= '0;
            r_gnt_id  <= '0;
        end else if (w_gnt_vld) begin
            r_we      <= w_addr_nz ? WR_EN : WR_DIS;
            r_flag_op <= !w_sel_flag ? FLAG_OP_DIS
                       : (w_addr_nz ? FLAG_OP_SET_AND_WR : FLAG_OP_SET);
            r_awr     <= w_sel_addr;
            r_din     <= w_sel_data;
            r_nflag   <= w_sel_nflag;
            r_gnt_id  <= 2'(w_gnt_idx);
        end else begin
            r_we      <= WR_DIS;
            r_flag_op <= FLAG_OP_DIS;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.WE        = r_we;
    assign bus.AWr       = r_awr;
    assign bus.Din       = r_din;
    assign bus.FlagOp    = r_flag_op;
    assign bus.NFlag     = r_nflag;
    assign bus.gnt_id    = r_gnt_id;
endmodule
